// File: rtl/neuron_weight_mac.sv
// neuron_weight_mac: fetches N Q8.8 weights plus a bias from RAM,
// multiply-accumulates them against neuron inputs and saturates to Q8.8.
module neuron_weight_mac #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 23,
    parameter int CNT_W  = 7,
    parameter int ACC_W  = 40
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  num_inputs,
    output logic [CNT_W-1:0]  in_idx,
    input  logic [DATA_W-1:0] in_data,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_latch,
    output logic              ram_instruction,
    input  logic              ram_ready,
    input  logic [DATA_W-1:0] ram_data_in,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic              overflow
);

    typedef enum logic [2:0] {
        IDLE, REQ, WAIT_ACK, WAIT_DATA, MAC, SAT, DONE
    } state_t;

    localparam logic signed [ACC_W-1:0] SAT_MAX =
        ACC_W'(2 ** (DATA_W - 1) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

    state_t                     state;
    logic [ADDR_W-1:0]          baseAddr;
    logic [CNT_W-1:0]           numIn;
    logic [CNT_W-1:0]           idx;
    logic signed [DATA_W-1:0]   word;
    logic signed [ACC_W-1:0]    acc;

    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]    prodExt;
    logic signed [ACC_W-1:0]    biasExt;
    logic signed [ACC_W-1:0]    satT;

    assign in_idx          = idx;
    assign ram_instruction = 1'b0;

    // Bias is Q8.8; shifting by 8 aligns it with the Q16.16 products.
    always_comb begin
        prod    = word * $signed(in_data);
        prodExt = {{(ACC_W - 2*DATA_W){prod[2*DATA_W-1]}}, prod};
        biasExt = {{(ACC_W - DATA_W - 8){word[DATA_W-1]}}, word, 8'b0};
        satT    = acc >>> 8;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            baseAddr  <= '0;
            numIn     <= '0;
            idx       <= '0;
            word      <= '0;
            acc       <= '0;
            ram_addr  <= '0;
            ram_latch <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
            overflow  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        baseAddr <= base_addr;
                        numIn    <= num_inputs;
                        acc      <= '0;
                        idx      <= '0;
                        busy     <= 1'b1;
                        state    <= REQ;
                    end
                end
                REQ: begin
                    if (ram_ready) begin
                        ram_addr  <= baseAddr + ADDR_W'(idx);
                        ram_latch <= 1'b1;
                        state     <= WAIT_ACK;
                    end
                end
                WAIT_ACK: begin
                    ram_latch <= 1'b0;
                    state     <= WAIT_DATA;
                end
                WAIT_DATA: begin
                    if (ram_ready) begin
                        word  <= ram_data_in;
                        state <= MAC;
                    end
                end
                MAC: begin
                    if (idx < numIn) begin
                        acc   <= acc + prodExt;
                        state <= REQ;
                    end else begin
                        acc   <= acc + biasExt;
                        state <= SAT;
                    end
                    idx <= idx + 1'b1;
                end
                SAT: begin
                    if (satT > SAT_MAX) begin
                        result   <= SAT_MAX[DATA_W-1:0];
                        overflow <= 1'b1;
                    end else if (satT < SAT_MIN) begin
                        result   <= SAT_MIN[DATA_W-1:0];
                        overflow <= 1'b1;
                    end else begin
                        result   <= satT[DATA_W-1:0];
                        overflow <= 1'b0;
                    end
                    done  <= 1'b1;
                    state <= DONE;
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_neuron_weight_mac.sv
// Directed bench for neuron_weight_mac with a behavioural RAM controller
// whose per-read wait is programmable.
module tb_neuron_weight_mac;

    localparam int DW = 16;
    localparam int AW = 23;
    localparam int CW = 7;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] baseAddr;
    logic [CW-1:0] numInputs;
    logic [CW-1:0] inIdx;
    logic [DW-1:0] inData;
    logic [AW-1:0] ramAddr;
    logic          ramLatch;
    logic          ramInstr;
    logic          ramReady;
    logic [DW-1:0] ramDataIn;
    logic          busy;
    logic          done;
    logic [DW-1:0] result;
    logic          overflow;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] inBuf [0:127];
    logic [DW-1:0] ram [int];

    neuron_weight_mac dut (
        .clk(clk), .rst(rst), .start(start),
        .base_addr(baseAddr), .num_inputs(numInputs),
        .in_idx(inIdx), .in_data(inData),
        .ram_addr(ramAddr), .ram_latch(ramLatch),
        .ram_instruction(ramInstr), .ram_ready(ramReady),
        .ram_data_in(ramDataIn), .busy(busy), .done(done),
        .result(result), .overflow(overflow)
    );

    always #5 clk = ~clk;

    assign inData = inBuf[inIdx];

    // Controller model: ready stays high for zero wait, otherwise low
    // for ctlWait sampling edges after the latch is seen.
    int            ctlWait = 0;
    int            ctlCnt = 0;
    logic          ctlReady = 1'b1;
    logic [DW-1:0] ctlData = '0;
    logic [AW-1:0] ctlAddr = '0;

    assign ramReady  = ctlReady;
    assign ramDataIn = ctlData;

    always @(posedge clk) begin
        if (ramLatch) begin
            ctlAddr <= ramAddr;
            ctlData <= ram[int'(ramAddr)];
            if (ctlWait == 0) begin
                ctlReady <= 1'b1;
            end else begin
                ctlReady <= 1'b0;
                ctlCnt   <= ctlWait;
            end
        end else if (ctlCnt > 1) begin
            ctlCnt <= ctlCnt - 1;
        end else if (ctlCnt == 1) begin
            ctlCnt   <= 0;
            ctlReady <= 1'b1;
        end
    end

    int            latchCnt = 0;
    int            doneCnt = 0;
    int            addrErr = 0;
    int            relatchErr = 0;
    logic [AW-1:0] latchQ [$];

    always @(posedge clk) begin
        if (ramLatch) begin
            latchCnt <= latchCnt + 1;
            latchQ.push_back(ramAddr);
        end
        if (done) doneCnt <= doneCnt + 1;
        if (!ctlReady && !rst) begin
            if (ramAddr !== ctlAddr) addrErr <= addrErr + 1;
            if (ramLatch) relatchErr <= relatchErr + 1;
        end
    end

    task automatic runNeuron(
        input  logic [AW-1:0] b,
        input  logic [CW-1:0] n,
        input  int            w,
        output logic [DW-1:0] res,
        output logic          ovf,
        output int            cyc
    );
        ctlWait = w;
        @(negedge clk);
        baseAddr  = b;
        numInputs = n;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc   = 1;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_on_start got %b want 1", busy);
        end
        while (done !== 1'b1 && cyc < 5000) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL done_timeout got %b want 1", done);
        end
        res = result;
        ovf = overflow;
        @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL done_pulse got done=%b busy=%b want 0 0",
                     done, busy);
        end
    endtask

    task automatic loadBasic();
        ram[32'h100] = 16'h0100;
        ram[32'h101] = 16'h0200;
        ram[32'h102] = 16'h0080;
        inBuf[0] = 16'h0180;
        inBuf[1] = 16'h0040;
    endtask

    task automatic checkResetOutputs(input string tag);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || ramLatch !== 1'b0 ||
            ramAddr !== '0 || result !== '0 || overflow !== 1'b0 ||
            inIdx !== '0 || ramInstr !== 1'b0) begin
            errors++;
            $display("FAIL %s got busy=%b done=%b latch=%b addr=%h res=%h ovf=%b idx=%0d instr=%b want all 0",
                     tag, busy, done, ramLatch, ramAddr, result,
                     overflow, inIdx, ramInstr);
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        start     = 1'b0;
        baseAddr  = '0;
        numInputs = '0;
        repeat (3) @(posedge clk);
        #1;
        checkResetOutputs("reset_state");
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_basic();
        logic [DW-1:0] res;
        logic          ovf;
        int            cyc;
        int            l0;
        int            d0;
        loadBasic();
        l0 = latchCnt;
        d0 = doneCnt;
        runNeuron(23'h100, 7'd2, 0, res, ovf, cyc);
        checks++;
        if (res !== 16'h0280 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL basic_result got %h/%b want 0280/0", res, ovf);
        end
        checks++;
        if (cyc != 14) begin
            errors++;
            $display("FAIL basic_latency got %0d want 14", cyc);
        end
        checks++;
        if (latchCnt - l0 != 3 || doneCnt - d0 != 1) begin
            errors++;
            $display("FAIL basic_counts got latches=%0d dones=%0d want 3 1",
                     latchCnt - l0, doneCnt - d0);
        end
        checks++;
        if (latchQ[l0] !== 23'h100 || latchQ[l0+1] !== 23'h101 ||
            latchQ[l0+2] !== 23'h102) begin
            errors++;
            $display("FAIL basic_addrs got %h %h %h want 100 101 102",
                     latchQ[l0], latchQ[l0+1], latchQ[l0+2]);
        end
    endtask

    task automatic test_saturation();
        logic [DW-1:0] res;
        logic          ovf;
        int            cyc;
        ram[32'h200] = 16'h7FFF;
        ram[32'h201] = 16'h0000;
        inBuf[0] = 16'h7FFF;
        runNeuron(23'h200, 7'd1, 0, res, ovf, cyc);
        checks++;
        if (res !== 16'h7FFF || ovf !== 1'b1) begin
            errors++;
            $display("FAIL sat_pos got %h/%b want 7fff/1", res, ovf);
        end
        ram[32'h200] = 16'h8000;
        runNeuron(23'h200, 7'd1, 0, res, ovf, cyc);
        checks++;
        if (res !== 16'h8000 || ovf !== 1'b1) begin
            errors++;
            $display("FAIL sat_neg got %h/%b want 8000/1", res, ovf);
        end
    endtask

    task automatic test_bias_only();
        logic [DW-1:0] res;
        logic          ovf;
        int            cyc;
        int            l0;
        ram[32'h300] = 16'hFF00;
        l0 = latchCnt;
        runNeuron(23'h300, 7'd0, 0, res, ovf, cyc);
        checks++;
        if (res !== 16'hFF00 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL bias_result got %h/%b want ff00/0", res, ovf);
        end
        checks++;
        if (cyc != 6 || latchCnt - l0 != 1) begin
            errors++;
            $display("FAIL bias_timing got cyc=%0d latches=%0d want 6 1",
                     cyc, latchCnt - l0);
        end
    endtask

    task automatic test_addr_wrap();
        logic [DW-1:0] res;
        logic          ovf;
        int            cyc;
        int            l0;
        ram[32'h7FFFFF] = 16'h0200;
        ram[32'h0]      = 16'h0100;
        inBuf[0] = 16'h0100;
        l0 = latchCnt;
        runNeuron(23'h7FFFFF, 7'd1, 0, res, ovf, cyc);
        checks++;
        if (res !== 16'h0300 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL wrap_result got %h/%b want 0300/0", res, ovf);
        end
        checks++;
        if (latchQ[l0] !== 23'h7FFFFF || latchQ[l0+1] !== 23'h000000) begin
            errors++;
            $display("FAIL wrap_addrs got %h %h want 7fffff 000000",
                     latchQ[l0], latchQ[l0+1]);
        end
    endtask

    task automatic test_stretch();
        logic [DW-1:0] res;
        logic          ovf;
        int            cyc;
        int            l0;
        int            a0;
        int            r0;
        loadBasic();
        l0 = latchCnt;
        a0 = addrErr;
        r0 = relatchErr;
        runNeuron(23'h100, 7'd2, 5, res, ovf, cyc);
        checks++;
        if (res !== 16'h0280 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL stretch_result got %h/%b want 0280/0", res, ovf);
        end
        checks++;
        if (cyc != 29 || latchCnt - l0 != 3) begin
            errors++;
            $display("FAIL stretch_timing got cyc=%0d latches=%0d want 29 3",
                     cyc, latchCnt - l0);
        end
        checks++;
        if (addrErr != a0 || relatchErr != r0) begin
            errors++;
            $display("FAIL stretch_stable got moves=%0d relatches=%0d want 0 0",
                     addrErr - a0, relatchErr - r0);
        end
        ctlWait = 0;
    endtask

    task automatic test_reset_mid();
        logic [DW-1:0] res;
        logic          ovf;
        int            cyc;
        int            l0;
        int            guard;
        loadBasic();
        ctlWait = 5;
        l0 = latchCnt;
        @(negedge clk);
        baseAddr  = 23'h100;
        numInputs = 7'd2;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        guard = 0;
        while (latchCnt - l0 < 2 && guard < 200) begin
            @(posedge clk);
            #1;
            guard++;
        end
        checks++;
        if (latchCnt - l0 < 2) begin
            errors++;
            $display("FAIL mid_reset_timeout got %0d latches want 2",
                     latchCnt - l0);
        end
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkResetOutputs("mid_reset");
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(posedge clk);
        runNeuron(23'h100, 7'd2, 0, res, ovf, cyc);
        checks++;
        if (res !== 16'h0280 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL after_reset got %h/%b want 0280/0", res, ovf);
        end
    endtask

    task automatic test_busy_start();
        logic [DW-1:0] res;
        logic          ovf;
        int            cyc;
        int            l0;
        int            d0;
        loadBasic();
        l0 = latchCnt;
        d0 = doneCnt;
        fork
            runNeuron(23'h100, 7'd2, 0, res, ovf, cyc);
            begin
                repeat (6) @(negedge clk);
                baseAddr  = 23'h300;
                numInputs = 7'd0;
                start     = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
        join
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (res !== 16'h0280 || busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_start_result got %h busy=%b want 0280 0",
                     res, busy);
        end
        checks++;
        if (latchCnt - l0 != 3 || doneCnt - d0 != 1) begin
            errors++;
            $display("FAIL busy_start_counts got latches=%0d dones=%0d want 3 1",
                     latchCnt - l0, doneCnt - d0);
        end
    endtask

    initial begin
        for (int i = 0; i < 128; i++) inBuf[i] = '0;
        test_reset();
        test_basic();
        test_saturation();
        test_bias_only();
        test_addr_wrap();
        test_stretch();
        test_reset_mid();
        test_busy_start();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
